// File: rtl/riscv_pkg.sv
// riscv_pkg: shared instruction constants and fetch FSM state encoding
package riscv_pkg;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;
  localparam int INST_BYTES = 4;
  typedef enum logic {FS_BOOT, FS_RUN} fetch_state_e;
endpackage

// File: rtl/fetch_perf_counters.sv
// fetch_perf_counters: saturating stall-cycle and flush event counters
module fetch_perf_counters (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_evt,
  input  logic        flush_evt,
  output logic [31:0] stall_cycles,
  output logic [31:0] flushes
);
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
      flushes <= '0;
    end else begin
      if (stall_evt && !(&stall_cycles)) stall_cycles <= stall_cycles + 32'd1;
      if (flush_evt && !(&flushes)) flushes <= flushes + 32'd1;
    end
  end
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC, synchronous imem driver and IF/ID register; perf counters under FETCH_PERF_EN
module fetch_stage
  import riscv_pkg::*;
#(
  parameter int WORD_BITWIDTH = 32,
  parameter logic [WORD_BITWIDTH-1:0] RESET_PC = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     stall,
  input  logic                     redirect_valid,
  input  logic [WORD_BITWIDTH-1:0] redirect_pc,
  output logic                     imem_en,
  output logic [WORD_BITWIDTH-1:0] imem_addr,
  input  logic [WORD_BITWIDTH-1:0] imem_rdata,
  output logic [WORD_BITWIDTH-1:0] ifid_pc,
  output logic [WORD_BITWIDTH-1:0] ifid_inst,
  output logic                     ifid_valid
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]              perf_stall_cycles,
  output logic [31:0]              perf_flushes
`endif
);
  localparam logic [WORD_BITWIDTH-1:0] STEP = WORD_BITWIDTH'(INST_BYTES);
  localparam logic [WORD_BITWIDTH-1:0] NOP = WORD_BITWIDTH'(NOP_INST);
  fetch_state_e state, next_state;
  logic [WORD_BITWIDTH-1:0] fetch_pc_q, seq_pc, target;
  logic advance;
  always_comb begin
    next_state = FS_RUN;
    target = redirect_pc & ~(STEP - 1'b1);
    seq_pc = fetch_pc_q + STEP;
    advance = state == FS_RUN && !stall && !redirect_valid;
    imem_en = !rst;
    imem_addr = rst ? RESET_PC :
                redirect_valid ? target :
                state == FS_BOOT ? RESET_PC :
                stall ? fetch_pc_q : seq_pc;
  end
  always_ff @(posedge clk) begin
    state <= rst ? FS_BOOT : next_state;
  end
  // The redirect outranks stall: the branch in EX is older than the stalled instruction.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      ifid_pc <= RESET_PC;
      ifid_inst <= NOP;
      ifid_valid <= 1'b0;
    end else if (redirect_valid) begin
      fetch_pc_q <= target;
      ifid_inst <= NOP;
      ifid_valid <= 1'b0;
    end else if (advance) begin
      fetch_pc_q <= seq_pc;
      ifid_pc <= fetch_pc_q;
      ifid_inst <= imem_rdata;
      ifid_valid <= 1'b1;
    end
  end
`ifdef FETCH_PERF_EN
  fetch_perf_counters u_perf (
    .clk(clk),
    .rst(rst),
    .stall_evt(state == FS_RUN && stall && !redirect_valid),
    .flush_evt(redirect_valid),
    .stall_cycles(perf_stall_cycles),
    .flushes(perf_flushes)
  );
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: scoreboard bench; a driver predicts each cycle from the fetch rules and monitors compare
module tb_fetch_stage;
  localparam logic [31:0] NOP = 32'h0000_0013;
  logic clk = 1'b0, rst = 1'b1, stall = 1'b0, redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0, imem_rdata = '0;
  logic imem_en, ifid_valid;
  logic [31:0] imem_addr, ifid_pc, ifid_inst;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_stall_cycles, perf_flushes;
`endif
  int checks = 0, fails = 0;
  typedef struct {logic [31:0] pc; logic [31:0] inst; logic valid; logic [31:0] ps; logic [31:0] pf;} ifid_t;
  ifid_t ifid_q[$];
  logic [32:0] addr_q[$];
  logic m_boot = 1'b1;
  logic [31:0] m_next = '0;
  ifid_t m = '{pc: 0, inst: NOP, valid: 1'b0, ps: 0, pf: 0};

  fetch_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_en(imem_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .ifid_pc(ifid_pc), .ifid_inst(ifid_inst), .ifid_valid(ifid_valid)
`ifdef FETCH_PERF_EN
    , .perf_stall_cycles(perf_stall_cycles), .perf_flushes(perf_flushes)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  always @(posedge clk) if (imem_en) imem_rdata <= mem_word(imem_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // One cycle: drive inputs, predict this cycle's fetch address and the IF/ID contents after the edge.
  task automatic cyc(input logic r, input logic s, input logic rv, input logic [31:0] rpc);
    logic [31:0] tgt;
    @(negedge clk);
    rst = r; stall = s; redirect_valid = rv; redirect_pc = rpc;
    #1;
    tgt = {rpc[31:2], 2'b00};
    addr_q.push_back({!r, r ? 32'h0 : rv ? tgt : m_boot ? 32'h0 : s ? m_next : m_next + 32'd4});
    if (r) begin
      m_boot = 1'b1; m_next = '0;
      m = '{pc: 0, inst: NOP, valid: 1'b0, ps: 0, pf: 0};
    end else if (rv) begin
      m_boot = 1'b0; m_next = tgt; m.valid = 1'b0; m.inst = NOP;
      if (m.pf != 32'hFFFF_FFFF) m.pf = m.pf + 1;
    end else if (m_boot) m_boot = 1'b0;
    else if (s) begin
      if (m.ps != 32'hFFFF_FFFF) m.ps = m.ps + 1;
    end else begin
      m.pc = m_next; m.inst = mem_word(m_next); m.valid = 1'b1; m_next = m_next + 32'd4;
    end
    ifid_q.push_back(m);
  endtask

  task automatic run(input int n, input logic r, input logic s, input logic rv, input logic [31:0] rpc);
    for (int i = 0; i < n; i++) cyc(r, s, rv, rpc);
  endtask

  always @(negedge clk) begin
    #2;
    if (addr_q.size() != 0) begin
      logic [32:0] e;
      e = addr_q.pop_front();
      chk("imem_en", {31'b0, imem_en}, {31'b0, e[32]});
      chk("imem_addr", imem_addr, e[31:0]);
    end
  end

  always @(posedge clk) begin
    #1;
    if (ifid_q.size() != 0) begin
      ifid_t e;
      e = ifid_q.pop_front();
      chk("ifid_valid", {31'b0, ifid_valid}, {31'b0, e.valid});
      chk("ifid_inst", ifid_inst, e.inst);
      if (e.valid) chk("ifid_pc", ifid_pc, e.pc);
`ifdef FETCH_PERF_EN
      chk("perf_stall_cycles", perf_stall_cycles, e.ps);
      chk("perf_flushes", perf_flushes, e.pf);
`endif
    end
  end

  initial begin
    run(3, 1, 0, 0, 0);
    run(5, 0, 0, 0, 0);
    run(3, 0, 1, 0, 0);
    run(3, 0, 0, 0, 0);
    cyc(0, 0, 1, 32'h100);
    run(3, 0, 0, 0, 0);
    cyc(0, 1, 1, 32'h200);
    run(3, 0, 0, 0, 0);
    cyc(0, 0, 1, 32'hFFFF_FFF3);
    run(7, 0, 0, 0, 0);
    run(2, 0, 1, 0, 0);
    cyc(1, 1, 0, 0);
    cyc(0, 0, 1, 32'h40);
    run(4, 0, 0, 0, 0);
    for (int i = 0; i < 600; i++) begin
      logic [31:0] rpc;
      rpc = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFF0 | ($urandom & 32'hF) : $urandom;
      cyc($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 25, $urandom_range(0, 99) < 10, rpc);
    end
    run(3, 0, 0, 0, 0);
    @(posedge clk);
    #3;
    if (ifid_q.size() != 0 || addr_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d ifid and %0d addr expectations left, required 0", ifid_q.size(), addr_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage: owns the PC, drives the synchronous instruction memory and holds the IF/ID pipeline register. It consumes the load-use stall produced by the hazard unit and the branch/jump redirect from EX, and delivers `{pc, inst, valid}` to decode. It freezes cleanly on a stall, inserts bubbles on a flush, and never loses or duplicates an instruction.

## Interface
- `WORD_BITWIDTH`, 32, PC and instruction width.
- `RESET_PC`, 32'h0000_0000, first fetch address after reset.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `stall`  in  1  hazard hold: freeze PC and IF/ID this cycle.
- `redirect_valid`  in  1  EX-resolved taken branch/jump; flushes IF/ID.
- `redirect_pc`  in  WORD_BITWIDTH  target address when `redirect_valid`.
- `imem_en`  out  1  instruction memory read enable.
- `imem_addr`  out  WORD_BITWIDTH  read address; data returns next cycle.
- `imem_rdata`  in  WORD_BITWIDTH  read data for the previous cycle's `imem_addr`.
- `ifid_pc`  out  WORD_BITWIDTH  PC of the instruction in IF/ID.
- `ifid_inst`  out  WORD_BITWIDTH  instruction in IF/ID; NOP when invalid.
- `ifid_valid`  out  1  IF/ID holds a real instruction.
- `perf_stall_cycles`, `perf_flushes`  out  32 each  only with `FETCH_PERF_EN`.

## Operation
- Registers: `fetch_pc_q` (address whose data is on `imem_rdata` this cycle), IF/ID `{pc, inst, valid}`, FSM state.
- FSM states:
  - BOOT: entered on `rst`. `imem_en=1`, `imem_addr=RESET_PC`. `imem_rdata` is not valid, so IF/ID is not written. Goes to RUN on the next cycle unconditionally.
  - RUN: the steady state.
- Priority within RUN, highest first:
  1. `redirect_valid`: `imem_addr=redirect_pc`. At the edge: `fetch_pc_q<=redirect_pc`, `ifid_valid<=0`, `ifid_inst<=NOP (32'h0000_0013)`. The wrong-path `imem_rdata` is discarded. `stall` is ignored because the branch is older.
  2. `stall`: `imem_addr=fetch_pc_q`, which re-reads the same word. `fetch_pc_q` and IF/ID are unchanged.
  3. Advance: `imem_addr=fetch_pc_q+4`. At the edge: `ifid_pc<=fetch_pc_q`, `ifid_inst<=imem_rdata`, `ifid_valid<=1`, `fetch_pc_q<=fetch_pc_q+4`.
- `redirect_valid` in BOOT: the redirect is taken, and the state still goes to RUN.
- PC arithmetic is modulo 2^WORD_BITWIDTH: 32'hFFFF_FFFC+4 wraps to 0 silently. `redirect_pc[1:0]` is ignored and treated as 0.
- `imem_en=1` in every cycle except while `rst` is high.

## Timing
- Reset values:
  - `ifid_valid=0`, `ifid_inst=NOP`, `ifid_pc=RESET_PC`, `fetch_pc_q=RESET_PC`, state BOOT.
  - `imem_en=0`, `imem_addr=RESET_PC`.
  - Perf counters 0.
- Fetch-to-IF/ID latency is 2 cycles: address at cycle t, data at t+1, registered at the end of t+1.
- First valid `ifid_*` appears in the 3rd cycle after `rst` falls (BOOT, RUN capture, visible).
- A redirect costs exactly one bubble in IF/ID. The target is in IF/ID two edges after the redirect cycle.
- A stall of N cycles holds IF/ID for N cycles. The instruction after the held one appears exactly once.
- `rst` mid-stream: everything returns to the reset values on the next edge. In-flight data is dropped.
- `imem_addr` is combinational from `redirect_valid`, `stall` and state. It must settle in the same cycle.

## Configuration
- `FETCH_PERF_EN` defined:
  - `perf_stall_cycles` increments in every RUN cycle with `stall && !redirect_valid`.
  - `perf_flushes` increments on every taken redirect.
  - Both saturate at 32'hFFFF_FFFF and clear on `rst`.
- Not defined: both ports and all counter logic are absent.

## Structure
- Shared package `riscv_pkg`:
  - `NOP_INST` (32'h0000_0013), `INST_BYTES` (4).
  - Fetch state enum `{FS_BOOT, FS_RUN}`.
- One sub-module, `fetch_perf_counters`, instantiated only under `FETCH_PERF_EN`. It takes `clk`, `rst`, `stall_evt`, `flush_evt`.

## Test plan
- Reset, then free-run with `imem_rdata=addr`:
  - Cycles 3, 4, 5 after `rst` falls show `ifid_pc`/`ifid_inst` = 0/0, 4/4, 8/8, with `ifid_valid=1`.
- `stall` for 3 cycles while IF/ID holds pc 8:
  - IF/ID stays at 8 for 3 cycles, then shows 12. No skip, no duplicate.
  - `imem_addr` holds 12 during the stall.
- `redirect_valid` with `redirect_pc=0x100`:
  - Next cycle `ifid_valid=0` and `ifid_inst=0x13`.
  - Following cycle `ifid_pc=0x100`.
- `stall` and `redirect_valid` asserted together:
  - Redirect wins, `imem_addr=redirect_pc`, one bubble, target delivered.
- Run until `fetch_pc_q=0xFFFF_FFFC`:
  - Next fetch address is 0, no error.
- Assert `rst` during a stall (with `FETCH_PERF_EN`):
  - All outputs return to reset values.
  - Counters read 0.
  - Boot sequence repeats from `RESET_PC`.
